mmu_host_rd_demux: RTL and testbench

- Sits directly downstream of the host-read arbiter in the MMU top level. Consumes the arbiter's mux ordering stream (vfid, len per issued host-read DMA) and the single host read-data AXI stream returned by the XDMA.
- Steers each DMA's data beats to the owning region's read-data stream, in issue order.
- Generates per-transfer tlast from the byte length and flags framing mismatches.

---
 rtl/mmu_host_rd_demux_pkg.sv | 26 ++
 rtl/mmu_host_rd_demux_fifo.sv | 45 ++++
 rtl/mmu_host_rd_demux.sv | 155 +++++++++++++++
 tb/tb_mmu_host_rd_demux.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_host_rd_demux_pkg.sv
// Shared types and constants for the MMU host-read data demultiplexer.
// Default bus geometry plus the ordering-entry layout used by the arbiter.
package mmu_host_rd_demux_pkg;

   localparam int AXI_DATA_BITS        = 512;
   localparam int N_REGIONS_DEF        = 4;
   localparam int N_REGIONS_BITS       = (N_REGIONS_DEF > 1) ? $clog2(N_REGIONS_DEF) : 1;
   localparam int LEN_BITS_DEF         = 28;
   localparam int MUX_DEPTH_DEF        = 16;
   localparam int HOST_BEAT_BYTES_BITS = $clog2(AXI_DATA_BITS / 8);

   typedef struct packed {
      logic [N_REGIONS_BITS-1:0] vfid;
      logic [LEN_BITS_DEF-1:0]   len;
   } mux_host_t;

   typedef enum logic {
      ST_IDLE,
      ST_ROUTE
   } demux_state_t;

   function automatic int region_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mmu_host_rd_demux_fifo.sv
// First-word-fall-through ordering FIFO for host-read mux entries.
// Pointers carry one extra wrap bit to tell full from empty.
module mmu_mux_fifo #(
   parameter int WIDTH = 30,
   parameter int DEPTH = 16
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign empty   = (wptr == rptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rptr[AW-1:0]];

   always_ff @(posedge aclk) begin
      if (areset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mmu_host_rd_demux.sv
// Steers host read-data beats to the owning region in arbiter issue order,
// regenerating tlast from the byte length of each ordering entry.
module mmu_host_rd_demux
   import mmu_host_rd_demux_pkg::*;
#(
   parameter int  N_REGIONS = N_REGIONS_DEF,
   parameter int  DATA_BITS = AXI_DATA_BITS,
   parameter int  LEN_BITS  = LEN_BITS_DEF,
   parameter int  MUX_DEPTH = MUX_DEPTH_DEF,
   localparam int NRB       = region_bits(N_REGIONS)
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   s_mux_valid,
   output logic                   s_mux_ready,
   input  logic [NRB-1:0]         s_mux_vfid,
   input  logic [LEN_BITS-1:0]    s_mux_len,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   input  logic [DATA_BITS-1:0]   s_axis_tdata,
   input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
   input  logic                   s_axis_tlast,
   output logic [N_REGIONS-1:0]   m_axis_tvalid,
   input  logic [N_REGIONS-1:0]   m_axis_tready,
   output logic [DATA_BITS-1:0]   m_axis_tdata,
   output logic [DATA_BITS/8-1:0] m_axis_tkeep,
   output logic                   m_axis_tlast,
   output logic                   err_tlast,
   output logic                   err_len_zero
);

   localparam int BYTES = DATA_BITS / 8;
   localparam int BB    = $clog2(BYTES);
   localparam int EW    = NRB + LEN_BITS;
   localparam int CW    = LEN_BITS + 1;

   typedef struct packed {
      logic [NRB-1:0]      vfid;
      logic [LEN_BITS-1:0] len;
   } entry_t;

   entry_t       push_ent;
   entry_t       head;
   logic         fifo_full;
   logic         fifo_empty;
   logic         fifo_push;
   logic         fifo_pop;
   logic         init_q;
   demux_state_t state;
   logic [NRB-1:0] cur_vfid;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  head_beats;
   logic         in_range;
   logic         head_ok;
   logic         sel_ready;
   logic         gen_last;
   logic         hs;

   function automatic logic [CW-1:0] beats_of(input logic [LEN_BITS-1:0] len);
      logic [CW-1:0] sum;
      sum = {1'b0, len} + CW'(BYTES - 1);
      return sum >> BB;
   endfunction

   // Ready stays low on the first cycle out of reset, then tracks full only.
   assign s_mux_ready = init_q && !fifo_full;
   assign fifo_push   = s_mux_valid && s_mux_ready;
   assign push_ent    = '{vfid: s_mux_vfid, len: s_mux_len};

   mmu_mux_fifo #(
      .WIDTH (EW),
      .DEPTH (MUX_DEPTH)
   ) u_fifo (
      .aclk   (aclk),
      .areset (areset),
      .push   (fifo_push),
      .din    (push_ent),
      .pop    (fifo_pop),
      .dout   (head),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign head_beats = beats_of(head.len);
   assign in_range   = {1'b0, head.vfid} < (NRB+1)'(N_REGIONS);
   assign head_ok    = !fifo_empty && (head.len != '0) && in_range;
   assign sel_ready  = m_axis_tready[cur_vfid];
   assign gen_last   = (cnt == CW'(1));
   assign hs         = (state == ST_ROUTE) && s_axis_tvalid && sel_ready;

   always_comb begin
      fifo_pop = 1'b0;
      unique case (state)
         ST_IDLE:  fifo_pop = !fifo_empty;
         ST_ROUTE: fifo_pop = hs && gen_last && head_ok;
         default:  fifo_pop = 1'b0;
      endcase
   end

   always_comb begin
      m_axis_tvalid = '0;
      s_axis_tready = 1'b0;
      if (state == ST_ROUTE) begin
         m_axis_tvalid[cur_vfid] = s_axis_tvalid;
         s_axis_tready           = sel_ready;
      end
   end

   assign m_axis_tdata = s_axis_tdata;
   assign m_axis_tkeep = s_axis_tkeep;
   assign m_axis_tlast = (state == ST_ROUTE) && gen_last;

   always_ff @(posedge aclk) begin
      if (areset) begin
         state        <= ST_IDLE;
         cur_vfid     <= '0;
         cnt          <= '0;
         init_q       <= 1'b0;
         err_tlast    <= 1'b0;
         err_len_zero <= 1'b0;
      end else begin
         init_q       <= 1'b1;
         err_tlast    <= hs && (s_axis_tlast != gen_last);
         err_len_zero <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  if (head_ok) begin
                     state    <= ST_ROUTE;
                     cur_vfid <= head.vfid;
                     cnt      <= head_beats;
                  end else begin
                     err_len_zero <= 1'b1;
                  end
               end
            end
            ST_ROUTE: begin
               if (hs) begin
                  if (!gen_last) begin
                     cnt <= cnt - 1'b1;
                  end else if (head_ok) begin
                     // Back-to-back load keeps the input stream bubble-free.
                     cur_vfid <= head.vfid;
                     cnt      <= head_beats;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mmu_host_rd_demux.sv
// Randomised bench for mmu_host_rd_demux against a queue-based model
// of issue-ordered, length-framed routing.
module tb_mmu_host_rd_demux;

   localparam int NR = 4;
   localparam int DB = 512;
   localparam int KB = 64;
   localparam int LB = 28;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic          s_mux_valid;
   logic          s_mux_ready;
   logic [1:0]    s_mux_vfid;
   logic [LB-1:0] s_mux_len;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [DB-1:0] s_axis_tdata;
   logic [KB-1:0] s_axis_tkeep;
   logic          s_axis_tlast;
   logic [NR-1:0] m_axis_tvalid;
   logic [NR-1:0] m_axis_tready;
   logic [DB-1:0] m_axis_tdata;
   logic [KB-1:0] m_axis_tkeep;
   logic          m_axis_tlast;
   logic          err_tlast;
   logic          err_len_zero;

   always #5 aclk = ~aclk;

   mmu_host_rd_demux dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_mux_valid   (s_mux_valid),
      .s_mux_ready   (s_mux_ready),
      .s_mux_vfid    (s_mux_vfid),
      .s_mux_len     (s_mux_len),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .err_tlast     (err_tlast),
      .err_len_zero  (err_len_zero)
   );

   typedef struct {
      logic [1:0]    vfid;
      logic [DB-1:0] data;
      logic [KB-1:0] keep;
      logic          last;
      logic          bad;
   } beat_t;

   typedef struct {
      logic [1:0]    vfid;
      logic [LB-1:0] len;
   } ent_t;

   ent_t  ent_q[$];
   beat_t drv_q[$];
   beat_t exp_q[$];
   int    hs_cyc[$];

   int checks = 0;
   int errors = 0;
   int exp_tl = 0;
   int exp_lz = 0;
   int got_tl = 0;
   int got_lz = 0;
   int push_cnt = 0;
   int hs_cnt = 0;
   int cyc = 0;
   bit mux_en = 0;
   bit data_en = 0;
   bit mon_en = 0;
   bit rdy_force = 1;
   logic [NR-1:0] rdy_mask = 4'hf;
   int mux_gap = 0;
   int data_gap = 0;
   int rdy_pct = 100;

   task automatic chk(input string tag, input logic [DB-1:0] got, input logic [DB-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DB-1:0] rnd_wide();
      logic [DB-1:0] r;
      for (int i = 0; i < DB / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Model: a transfer of len bytes is ceil(len/64) beats, last on the final one.
   task automatic add_entry(input int v, input int l, input int mask, input int pct);
      ent_t  e;
      beat_t b;
      int    nb;
      e.vfid = 2'(v);
      e.len  = LB'(l);
      ent_q.push_back(e);
      if (l == 0) begin
         exp_lz++;
      end else begin
         nb = (l + KB - 1) / KB;
         for (int i = 0; i < nb; i++) begin
            b.vfid = e.vfid;
            b.data = rnd_wide();
            b.keep = {$urandom, $urandom};
            b.last = (i == nb - 1);
            b.bad  = ((i < 32) && mask[i]) || (int'($urandom_range(99)) < pct);
            if (b.bad) exp_tl++;
            drv_q.push_back(b);
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic check_errs(input string tag);
      chk({tag, "_err_tlast_cnt"}, got_tl, exp_tl);
      chk({tag, "_err_len_zero_cnt"}, got_lz, exp_lz);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((ent_q.size() + drv_q.size() + exp_q.size()) != 0 && n < 4000) begin
         @(posedge aclk);
         n++;
      end
      chk({tag, "_drained"}, (n < 4000), 1);
      repeat (6) @(posedge aclk);
      check_errs(tag);
   endtask

   task automatic wait_hs(input int h0);
      int n;
      n = 0;
      while (hs_cnt <= h0 && n < 200) begin
         @(posedge aclk);
         n++;
      end
      chk("wait_hs", (hs_cnt > h0), 1);
   endtask

   // Ordering-entry driver.
   initial begin
      int n;
      s_mux_valid = 0;
      s_mux_vfid  = '0;
      s_mux_len   = '0;
      forever begin
         @(posedge aclk);
         #1;
         if (mux_en && ent_q.size() > 0 && int'($urandom_range(99)) >= mux_gap) begin
            s_mux_valid = 1;
            s_mux_vfid  = ent_q[0].vfid;
            s_mux_len   = ent_q[0].len;
            n = 0;
            @(negedge aclk);
            while (!s_mux_ready && n < 600) begin
               @(negedge aclk);
               n++;
            end
            if (!s_mux_ready) chk("mux_timeout", 0, 1);
            void'(ent_q.pop_front());
            push_cnt++;
         end else begin
            s_mux_valid = 0;
         end
      end
   end

   // Host read-data driver.
   initial begin
      beat_t b;
      int    n;
      s_axis_tvalid = 0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tlast  = 0;
      forever begin
         @(posedge aclk);
         #1;
         if (data_en && drv_q.size() > 0 && int'($urandom_range(99)) >= data_gap) begin
            b = drv_q[0];
            s_axis_tvalid = 1;
            s_axis_tdata  = b.data;
            s_axis_tkeep  = b.keep;
            s_axis_tlast  = b.last ^ b.bad;
            n = 0;
            @(negedge aclk);
            while (!s_axis_tready && n < 400) begin
               @(negedge aclk);
               n++;
            end
            if (!s_axis_tready) chk("data_timeout", 0, 1);
            void'(drv_q.pop_front());
         end else begin
            s_axis_tvalid = 0;
         end
      end
   end

   // Region back-pressure.
   initial begin
      m_axis_tready = 4'hf;
      forever begin
         @(posedge aclk);
         #1;
         if (rdy_force) m_axis_tready = rdy_mask;
         else for (int i = 0; i < NR; i++)
            m_axis_tready[i] = (int'($urandom_range(99)) < rdy_pct);
      end
   end

   // Output monitor, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge aclk);
         cyc++;
         if (!areset) begin
            if (err_tlast) got_tl++;
            if (err_len_zero) got_lz++;
            if (mon_en && m_axis_tvalid != '0) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_valid", m_axis_tvalid, 0);
               end else begin
                  chk("route_vfid", m_axis_tvalid, 4'b0001 << exp_q[0].vfid);
                  chk("tdata", m_axis_tdata, exp_q[0].data);
                  chk("tkeep", m_axis_tkeep, exp_q[0].keep);
                  chk("tlast", m_axis_tlast, exp_q[0].last);
                  if ((m_axis_tvalid & m_axis_tready) != '0) begin
                     void'(exp_q.pop_front());
                     hs_cnt++;
                     hs_cyc.push_back(cyc);
                  end
               end
            end
            if (mon_en && s_axis_tvalid && s_axis_tready)
               chk("in_out_hs", |(m_axis_tvalid & m_axis_tready), 1);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int h0;
      int n;

      areset = 1;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk("rst_mux_ready", s_mux_ready, 0);
      chk("rst_s_tready", s_axis_tready, 0);
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_err_tlast", err_tlast, 0);
      chk("rst_err_len_zero", err_len_zero, 0);
      @(posedge aclk);
      #1 areset = 0;
      @(negedge aclk);
      chk("ready_first_cycle", s_mux_ready, 0);
      @(negedge aclk);
      chk("ready_after_reset", s_mux_ready, 1);
      mon_en = 1;
      mux_en = 1;

      // Two-beat transfer to region 2.
      data_en = 1;
      add_entry(2, 128, 0, 0);
      drain("t1");

      // Back-to-back transfers with no bubble between them.
      data_en = 0;
      add_entry(1, 65, 0, 0);
      add_entry(3, 64, 0, 0);
      while (ent_q.size() != 0) @(posedge aclk);
      repeat (4) @(posedge aclk);
      hs_cyc.delete();
      data_en = 1;
      drain("t2");
      chk("t2_beats", hs_cyc.size(), 3);
      if (hs_cyc.size() == 3) begin
         chk("t2_gap01", hs_cyc[1] - hs_cyc[0], 1);
         chk("t2_gap12", hs_cyc[2] - hs_cyc[1], 1);
      end

      // Stalled destination stalls the input.
      rdy_mask = 4'b1110;
      repeat (2) @(posedge aclk);
      add_entry(0, 64, 0, 0);
      n = 0;
      @(negedge aclk);
      while (!(s_axis_tvalid && m_axis_tvalid == 4'b0001) && n < 100) begin
         @(negedge aclk);
         n++;
      end
      chk("t3_routed", m_axis_tvalid, 4'b0001);
      for (int i = 0; i < 5; i++) begin
         chk("t3_stall_tready", s_axis_tready, 0);
         chk("t3_stall_valid", m_axis_tvalid, 4'b0001);
         @(negedge aclk);
      end
      @(posedge aclk);
      rdy_mask = 4'hf;
      @(negedge aclk);
      chk("t3_release", s_axis_tready, 1);
      drain("t3");

      // Fill the ordering FIFO with data held off.
      data_en = 0;
      p0 = push_cnt;
      for (int i = 0; i < 18; i++) add_entry($urandom_range(3), 64, 0, 0);
      n = 0;
      while (push_cnt < p0 + 17 && n < 300) begin
         @(posedge aclk);
         n++;
      end
      repeat (4) @(posedge aclk);
      @(negedge aclk);
      chk("t4_full_ready", s_mux_ready, 0);
      chk("t4_pushes", push_cnt - p0, 17);
      h0 = hs_cnt;
      data_en = 1;
      wait_hs(h0);
      data_en = 0;
      @(negedge aclk);
      chk("t4_ready_back", s_mux_ready, 1);
      data_en = 1;
      drain("t4");

      // Zero-length entry is dropped.
      add_entry(2, 0, 0, 0);
      add_entry(1, 64, 0, 0);
      drain("t5");

      // Input tlast one beat early on a three-beat transfer.
      add_entry(1, 192, 32'b010, 0);
      drain("t6");

      // Random traffic with random back-pressure and gaps.
      rdy_force = 0;
      rdy_pct   = 75;
      mux_gap   = 30;
      data_gap  = 30;
      for (int i = 0; i < 60; i++)
         add_entry($urandom_range(3), ($urandom_range(7) == 0) ? 0 : $urandom_range(1, 300), 0, 8);
      drain("rnd_a");

      // Full-speed random traffic, exercising pointer wrap.
      rdy_force = 1;
      rdy_mask  = 4'hf;
      mux_gap   = 0;
      data_gap  = 0;
      for (int i = 0; i < 40; i++)
         add_entry($urandom_range(3), ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 200), 0, 5);
      drain("rnd_b");

      // Reset in the middle of a transfer.
      data_en = 0;
      add_entry(1, 192, 0, 0);
      add_entry(2, 64, 0, 0);
      while (ent_q.size() != 0) @(posedge aclk);
      repeat (3) @(posedge aclk);
      h0 = hs_cnt;
      data_en = 1;
      wait_hs(h0);
      data_en = 0;
      #1 areset = 1;
      @(posedge aclk);
      @(negedge aclk);
      chk("mrst_mux_ready", s_mux_ready, 0);
      chk("mrst_s_tready", s_axis_tready, 0);
      chk("mrst_m_tvalid", m_axis_tvalid, 0);
      chk("mrst_err_tlast", err_tlast, 0);
      chk("mrst_err_len_zero", err_len_zero, 0);
      drv_q.delete();
      exp_q.delete();
      @(posedge aclk);
      #1 areset = 0;
      @(negedge aclk);
      chk("mrst_ready_first", s_mux_ready, 0);
      @(negedge aclk);
      chk("mrst_ready_after", s_mux_ready, 1);
      data_en = 1;
      add_entry(3, 64, 0, 0);
      drain("mrst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
